// File: rtl/alu_rx_sequencer.sv
// alu_rx_sequencer: loads A, B, opcode from rx bytes into the ALU and forwards the result to tx
module alu_rx_sequencer #(
    parameter int NB_DATA        = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int NB_TIMEOUT     = 16,
    parameter int NB_DROP        = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_alu_data,
    output logic [2:0]         o_alu_valid,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_timeout,
    output logic [NB_DROP-1:0] o_drop_count
);
    typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, SETTLE, LATCH, WAIT_TX} state_t;
    localparam bit TMO_EN = TIMEOUT_CYCLES > 0;
    localparam logic [NB_TIMEOUT-1:0] TMO_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);
    state_t               state_q, state_d;
    logic [NB_DATA-1:0]   alu_data_q, alu_data_d, tx_data_q, tx_data_d;
    logic [2:0]           alu_valid_q, alu_valid_d;
    logic                 tx_start_q, tx_start_d, busy_q, busy_d, timeout_q, timeout_d;
    logic [NB_TIMEOUT-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [NB_DROP-1:0]   drop_q, drop_d;
    logic                 is_b, drop;
    always_comb begin
        state_d     = state_q;
        alu_data_d  = alu_data_q;
        alu_valid_d = 3'b000;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        timeout_d   = 1'b0;
        tmo_cnt_d   = '0;
        is_b        = state_q == WAIT_B;
        drop        = i_rx_done && (state_q == SETTLE || state_q == LATCH || state_q == WAIT_TX);
        case (state_q)
            WAIT_A: if (i_rx_done) begin
                alu_data_d  = i_rx_data;
                alu_valid_d = 3'b001;
                state_d     = WAIT_B;
            end
            WAIT_B, WAIT_OP: begin
                if (i_rx_done) begin
                    alu_data_d  = i_rx_data;
                    alu_valid_d = is_b ? 3'b010 : 3'b100;
                    state_d     = is_b ? WAIT_OP : SETTLE;
                end else if (TMO_EN && tmo_cnt_q == TMO_LAST) begin
                    // loaded ALU registers are left as they are; only the frame restarts
                    state_d   = WAIT_A;
                    timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = TMO_EN ? tmo_cnt_q + 1'b1 : '0;
                end
            end
            SETTLE:  state_d = LATCH;
            LATCH: begin
                tx_data_d  = i_alu_result;
                tx_start_d = 1'b1;
                state_d    = WAIT_TX;
            end
            WAIT_TX: state_d = i_tx_done ? WAIT_A : WAIT_TX;
            default: state_d = WAIT_A;
        endcase
        drop_d = (drop && drop_q != '1) ? drop_q + 1'b1 : drop_q;
        busy_d = state_d != WAIT_A;
    end
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= WAIT_A;
            alu_data_q  <= '0;
            alu_valid_q <= 3'b000;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            tmo_cnt_q   <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            alu_data_q  <= alu_data_d;
            alu_valid_q <= alu_valid_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            tmo_cnt_q   <= tmo_cnt_d;
            drop_q      <= drop_d;
        end
    end
    assign o_alu_data   = alu_data_q;
    assign o_alu_valid  = alu_valid_q;
    assign o_tx_data    = tx_data_q;
    assign o_tx_start   = tx_start_q;
    assign o_busy       = busy_q;
    assign o_timeout    = timeout_q;
    assign o_drop_count = drop_q;
endmodule

// File: tb/tb_alu_rx_sequencer.sv
// tb_alu_rx_sequencer: directed and randomized frames against a register-loaded ALU stand-in
module tb_alu_rx_sequencer;
    logic       clk = 1'b0, rst = 1'b1;
    logic [7:0] rx_data = '0, alu_res, alu_data, tx_data, drop_count;
    logic       rx_done = 1'b0, tx_done = 1'b0, tx_start, busy, timeout;
    logic [2:0] alu_valid;
    logic [7:0] ra, rb, rop;
    int         checks = 0, failures = 0, drop_exp = 0;
    logic [7:0] ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03};

    alu_rx_sequencer #(.NB_DATA(8), .TIMEOUT_CYCLES(16), .NB_TIMEOUT(16), .NB_DROP(8)) dut (
        .i_clock(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_alu_result(alu_res), .i_tx_done(tx_done), .o_alu_data(alu_data),
        .o_alu_valid(alu_valid), .o_tx_data(tx_data), .o_tx_start(tx_start),
        .o_busy(busy), .o_timeout(timeout), .o_drop_count(drop_count));

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [7:0] a, b, op);
        case (op)
            8'h20: return a + b;
            8'h22: return a - b;
            8'h24: return a & b;
            8'h25: return a | b;
            8'h26: return a ^ b;
            8'h27: return ~(a | b);
            8'h02: return a >> b;
            8'h03: return 8'($signed(a) >>> b);
            default: return 8'h00;
        endcase
    endfunction

    // ALU stand-in: registers load on the strobes, result is combinational
    always @(posedge clk) begin
        if (rst) begin
            ra <= '0; rb <= '0; rop <= '0;
        end else begin
            if (alu_valid[0]) ra <= alu_data;
            if (alu_valid[1]) rb <= alu_data;
            if (alu_valid[2]) rop <= alu_data;
        end
    end
    assign alu_res = alu_ref(ra, rb, rop);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            check("idle_timeout", timeout, 0);
            check("idle_valid", alu_valid, 0);
        end
    endtask

    task automatic load(input logic [7:0] a, b, op, input int g1, input int g2);
        send_byte(a);
        check("a_valid", alu_valid, 3'b001);
        check("a_data", alu_data, a);
        check("a_busy", busy, 1);
        idle(g1);
        send_byte(b);
        check("b_valid", alu_valid, 3'b010);
        check("b_data", alu_data, b);
        idle(g2);
        send_byte(op);
        check("op_valid", alu_valid, 3'b100);
        check("op_data", alu_data, op);
        tick();
        check("settle_start", tx_start, 0);
        check("settle_valid", alu_valid, 0);
        tick();
        check("latch_start", tx_start, 1);
        check("latch_txdata", tx_data, alu_ref(a, b, op));
        tick();
        check("wait_tx_start", tx_start, 0);
        check("wait_tx_busy", busy, 1);
    endtask

    task automatic finish_tx();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("tx_done_busy", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a, b, op;
        tick();
        tick();
        check("rst_alu_data", alu_data, 0);
        check("rst_valid", alu_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);
        check("rst_drop", drop_count, 0);
        rst = 1'b0;
        tick();

        load(8'h05, 8'h03, 8'h20, 0, 0);
        check("add_result", tx_data, 8'h08);
        finish_tx();
        load(8'h03, 8'h05, 8'h22, 0, 0);
        check("sub_result", tx_data, 8'hFE);
        finish_tx();
        load(8'hF0, 8'h0F, 8'h25, 0, 0);
        check("or_result", tx_data, 8'hFF);
        finish_tx();

        send_byte(8'h11);
        idle(15);
        tick();
        check("tmo_pulse", timeout, 1);
        check("tmo_busy", busy, 0);
        tick();
        check("tmo_once", timeout, 0);
        load(8'h01, 8'h01, 8'h20, 0, 0);
        check("post_tmo_result", tx_data, 8'h02);
        finish_tx();

        send_byte(8'h07);
        idle(15);
        send_byte(8'h09);
        check("expiry_valid", alu_valid, 3'b010);
        check("expiry_timeout", timeout, 0);
        check("expiry_busy", busy, 1);
        send_byte(8'h20);
        tick();
        tick();
        check("expiry_result", tx_data, 8'h10);
        finish_tx();

        send_byte(8'h01);
        send_byte(8'h02);
        idle(15);
        tick();
        check("tmo_op_pulse", timeout, 1);
        check("tmo_op_busy", busy, 0);

        for (int i = 0; i < 30; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            op = ops[$urandom_range(0, 7)];
            load(a, b, op, $urandom_range(0, 15), $urandom_range(0, 15));
            idle($urandom_range(0, 3));
            finish_tx();
        end

        load(8'h0A, 8'h0B, 8'h26, 0, 0);
        repeat (3) begin
            send_byte(8'($urandom));
            idle(1);
        end
        drop_exp = 3;
        check("drop3", drop_count, drop_exp);
        check("drop3_busy", busy, 1);
        rx_done = 1'b1;
        tx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        tx_done = 1'b0;
        drop_exp = (drop_exp + 1 > 255) ? 255 : drop_exp + 1;
        check("same_cycle_busy", busy, 0);
        check("same_cycle_drop", drop_count, drop_exp);
        load(8'h33, 8'h11, 8'h24, 0, 0);
        rx_done = 1'b1;
        repeat (300) tick();
        rx_done = 1'b0;
        drop_exp = (drop_exp + 300 > 255) ? 255 : drop_exp + 300;
        check("drop_sat", drop_count, drop_exp);
        check("drop_sat_busy", busy, 1);
        finish_tx();

        send_byte(8'h44);
        send_byte(8'h55);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_alu_data", alu_data, 0);
        check("mid_rst_valid", alu_valid, 0);
        check("mid_rst_tx_data", tx_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_drop", drop_count, 0);
        load(8'h06, 8'h02, 8'h22, 2, 1);
        check("post_rst_result", tx_data, 8'h04);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (5) begin
            tick();
            check("tx_rst_start", tx_start, 0);
            check("tx_rst_busy", busy, 0);
        end
        check("tx_rst_tx_data", tx_data, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_rx_sequencer.md
Name: alu_rx_sequencer

Overview:
- Upstream control stage for the register-loaded ALU; it also routes the ALU result onward.
- Consumes a byte stream from the serial receiver and loads operand A, operand B and the opcode into the ALU, in that order, through the ALU's shared data bus and one-hot load strobes.
- Once the opcode is loaded and the ALU output has settled, it captures the result and hands it to the serial transmitter with a start/done handshake.
- Adds an inter-byte timeout and a saturating counter of dropped bytes.

Parameters:
- NB_DATA, 8, width of data bytes, ALU operands and result.
- TIMEOUT_CYCLES, 50000, maximum cycles allowed between bytes of one frame; 0 disables the timeout.
- NB_TIMEOUT, 16, width of the timeout counter; must hold TIMEOUT_CYCLES.
- NB_DROP, 8, width of the dropped-byte counter.

Ports:
- i_clock  in  1  single clock; all logic on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_data  in  NB_DATA  received byte; valid only while i_rx_done=1.
- i_rx_done  in  1  one-cycle pulse: byte available.
- i_alu_result  in  NB_DATA  combinational ALU result.
- i_tx_done  in  1  one-cycle pulse: transmitter finished the byte.
- o_alu_data  out  NB_DATA  byte driven onto the ALU data bus.
- o_alu_valid  out  3  one-hot load strobe: bit0 = A, bit1 = B, bit2 = opcode.
- o_tx_data  out  NB_DATA  result byte for the transmitter.
- o_tx_start  out  1  one-cycle start pulse to the transmitter.
- o_busy  out  1  high in every state except WAIT_A.
- o_timeout  out  1  one-cycle pulse when a frame is aborted by timeout.
- o_drop_count  out  NB_DROP  saturating count of discarded rx bytes.

Behaviour:
- All outputs are registered. Reset clears every output and counter to 0 and sets state to WAIT_A. Reset is honoured in any state, including mid-frame and mid-transmit; the ALU shares the same reset.
- States: WAIT_A, WAIT_B, WAIT_OP, SETTLE, LATCH, WAIT_TX.
- Byte acceptance: on an edge sampling i_rx_done=1 in WAIT_A, WAIT_B or WAIT_OP:
  - o_alu_data <= i_rx_data.
  - o_alu_valid <= 001, 010 or 100 respectively.
  - State advances to WAIT_B, WAIT_OP or SETTLE respectively.
- o_alu_valid is high for exactly one cycle and is 000 otherwise. o_alu_data holds its last value.
- SETTLE: one cycle; the ALU captures the opcode at this edge. Then go to LATCH.
- LATCH: one cycle.
  - o_tx_data <= i_alu_result; o_tx_start <= 1 for exactly one cycle.
  - Go to WAIT_TX.
  - Latency: opcode i_rx_done sampled at edge E0 → o_tx_start high after edge E2.
- WAIT_TX: on i_tx_done=1, go to WAIT_A. There is no timeout in WAIT_TX.
- Dropped bytes: i_rx_done=1 in SETTLE, LATCH or WAIT_TX discards the byte and increments o_drop_count, saturating at all-ones.
  - i_tx_done and i_rx_done in the same WAIT_TX cycle: return to WAIT_A, and the byte is dropped and counted.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter clears on every accepted byte and counts each cycle in WAIT_B and WAIT_OP.
  - When it reaches TIMEOUT_CYCLES-1 with no i_rx_done, go to WAIT_A, pulse o_timeout for one cycle and clear the counter.
  - Already-loaded ALU registers are left unchanged.
  - If i_rx_done arrives in the expiry cycle, the byte wins: it is accepted normally and no timeout occurs.
- The counter stays 0 in all other states.

Test Plan:
- ADD frame: bytes 0x05, 0x03, 0x20 → o_alu_valid pulses 001/010/100 with o_alu_data 0x05/0x03/0x20; o_tx_start pulses 2 cycles after the opcode byte with o_tx_data=0x08. After i_tx_done: o_busy=0.
- SUB frame: bytes 0x03, 0x05, 0x22 → o_tx_data=0xFE. Then a back-to-back second frame 0xF0, 0x0F, 0x25 → o_tx_data=0xFF.
- Timeout (TIMEOUT_CYCLES=16): send 0x11 then idle 16 cycles → o_timeout pulses once, state WAIT_A. Next bytes 0x01, 0x01, 0x20 → o_tx_data=0x02. Repeat with a byte in the exact expiry cycle → no o_timeout, byte loaded as B.
- Drops: 3 bytes during WAIT_TX → o_drop_count=3. Then 300 drops → o_drop_count stays 0xFF. Same-cycle rx_done+tx_done → state WAIT_A and the count increments.
- Reset mid-frame: after A and B are loaded, assert i_reset for one cycle → all outputs 0, state WAIT_A. Reset during WAIT_TX → o_tx_start never re-pulses, o_busy=0.
